// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace buffer: state encoding and probe-channel slicing.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } trace_state_e;

  localparam int PC_CH = 0;

  // Bit offset of channel ch inside a packed probe word of dw-bit channels.
  function automatic int ch_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: synchronous write, combinational read, no reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture for the single-cycle CPU: circular sample buffer with PC trigger
// or stop-when-full capture, drained oldest-first over a valid/ready port.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     probe_valid,
  input  logic [NUM_CH*DATA_W-1:0] probe_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [AW:0]              fill,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic                     overwrote
);

  localparam int          W      = NUM_CH * DATA_W;
  localparam int          PC_LSB = ch_lsb(PC_CH, DATA_W);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

  trace_state_e      state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [AW:0]       unread_q, unread_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic              triggered_q, triggered_d;
  logic              overwrote_q, overwrote_d;
  logic              trig_en_q, trig_en_d;
  logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_en;
  logic              go_readout;
  logic              pc_match;
  logic [AW:0]       fill_inc;
  logic [W-1:0]      ram_rdata;

  // Live, unregistered compare so the matching sample itself is the trigger.
  assign pc_match = (probe_in[PC_LSB +: DATA_W] == trig_pc_q);
  assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    unread_d    = unread_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overwrote_d = overwrote_q;
    trig_en_d   = trig_en_q;
    trig_pc_d   = trig_pc_q;
    rd_valid_d  = rd_valid_q;
    wr_en       = 1'b0;
    go_readout  = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      fill_d      = '0;
      unread_d    = '0;
      post_cnt_d  = '0;
      rd_valid_d  = 1'b0;
      triggered_d = 1'b0;
      overwrote_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            trig_en_d   = trig_en;
            trig_pc_d   = trig_pc;
            wr_ptr_d    = '0;
            fill_d      = '0;
            triggered_d = 1'b0;
            overwrote_d = 1'b0;
            state_d     = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (probe_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_inc;
            if (trig_en_q) begin
              if (fill_q == FULL) overwrote_d = 1'b1;
              if (pc_match) begin
                triggered_d = 1'b1;
                post_cnt_d  = AW'(POST_TRIG);
                if (POST_TRIG == 0) go_readout = 1'b1;
                else                state_d    = ST_POST;
              end
            end else if (fill_inc == FULL) begin
              go_readout = 1'b1;
            end
          end
        end
        ST_POST: begin
          if (probe_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_d     = fill_inc;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) go_readout = 1'b1;
          end
        end
        ST_READOUT: begin
          // A transfer happens on any cycle with rd_valid && rd_ready; rd_data is
          // held unchanged while rd_valid && !rd_ready.
          if (rd_valid_q && rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            unread_d = unread_q - 1'b1;
            if (unread_q == (AW+1)'(1)) begin
              rd_valid_d = 1'b0;
              fill_d     = '0;
              state_d    = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // fill == DEPTH truncates to 0 in AW bits, which is the same pointer mod DEPTH.
      if (go_readout) begin
        state_d    = ST_READOUT;
        rd_ptr_d   = wr_ptr_d - fill_d[AW-1:0];
        unread_d   = fill_d;
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      unread_q    <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overwrote_q <= 1'b0;
      trig_en_q   <= 1'b0;
      trig_pc_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      unread_q    <= unread_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overwrote_q <= overwrote_d;
      trig_en_q   <= trig_en_d;
      trig_pc_q   <= trig_pc_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (probe_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign fill      = fill_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overwrote = overwrote_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized scoreboard bench for cpu_trace_buffer against a sample-history model.
module tb_cpu_trace_buffer;

  localparam int DATA_W    = 32;
  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 4;
  localparam int POST_TRIG = 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int W         = NUM_CH * DATA_W;

  logic              CLK, Reset;
  logic              arm, abort, trig_en, probe_valid, rd_ready;
  logic [DATA_W-1:0] trig_pc;
  logic [W-1:0]      probe_in;
  logic              rd_valid, triggered, overwrote;
  logic [W-1:0]      rd_data;
  logic [AW:0]       fill;
  logic [1:0]        state;

  cpu_trace_buffer #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .CLK(CLK), .Reset(Reset), .arm(arm), .abort(abort), .trig_en(trig_en),
    .trig_pc(trig_pc), .probe_valid(probe_valid), .probe_in(probe_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .fill(fill),
    .state(state), .triggered(triggered), .overwrote(overwrote)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: the ordered list of samples accepted since arm.
  logic [W-1:0]      m_hist[$];
  bit                m_active = 0;
  bit                m_trig_en;
  logic [DATA_W-1:0] m_trig_pc;
  int                m_post = -1;
  bit                m_trig = 0;
  bit                m_ovw = 0;
  int                exp_fill = 0;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- model ----------------
  function automatic void model_finish();
    int start;
    m_active = 0;
    start    = (m_hist.size() > DEPTH) ? m_hist.size() - DEPTH : 0;
    exp_fill = m_hist.size() - start;
    for (int i = start; i < m_hist.size(); i++) exp_q.push_back(m_hist[i]);
  endfunction

  function automatic void model_sample(input logic [W-1:0] s);
    if (!m_active) return;
    m_hist.push_back(s);
    if (m_post > 0) begin
      m_post--;
      if (m_post == 0) model_finish();
    end else if (m_trig_en) begin
      if (m_hist.size() > DEPTH) m_ovw = 1;
      if (s[DATA_W-1:0] == m_trig_pc) begin
        m_trig = 1;
        m_post = POST_TRIG;
        if (POST_TRIG == 0) model_finish();
      end
    end else if (m_hist.size() == DEPTH) begin
      model_finish();
    end
  endfunction

  function automatic void model_clear();
    m_active = 0;
    m_hist.delete();
    exp_q.delete();
    m_post = -1;
    m_trig = 0;
    m_ovw  = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_arm(input bit en, input logic [DATA_W-1:0] pc);
    arm = 1'b1; trig_en = en; trig_pc = pc;
    model_clear();
    m_active = 1; m_trig_en = en; m_trig_pc = pc;
    tick();
    arm = 1'b0; trig_en = $urandom_range(0, 1); trig_pc = $urandom();
    chk("arm_state", W'(state), W'(1));
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] pc);
    logic [W-1:0] s;
    s = {$urandom(), $urandom(), $urandom(), pc};
    probe_valid = 1'b1;
    probe_in    = s;
    model_sample(s);
    tick();
    probe_valid = 1'b0;
    probe_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic idle_cycle();
    probe_valid = 1'b0;
    probe_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
  endtask

  task automatic check_capture(input string tag);
    chk({tag, "_state"}, W'(state), W'(3));
    chk({tag, "_fill"}, W'(fill), W'(exp_fill));
    chk({tag, "_trig"}, W'(triggered), W'(m_trig));
    chk({tag, "_ovw"}, W'(overwrote), W'(m_ovw));
    chk({tag, "_rdv"}, W'(rd_valid), W'(1));
  endtask

  task automatic run_capture(input string tag, input logic [DATA_W-1:0] pc0, input bit gaps);
    logic [DATA_W-1:0] pc;
    int guard;
    pc = pc0;
    guard = 0;
    while (m_active && guard < 300) begin
      if (gaps && $urandom_range(0, 2) == 0) idle_cycle();
      else begin
        send_sample(pc);
        pc += 4;
      end
      guard++;
    end
    chk({tag, "_timeout"}, W'(m_active), W'(0));
    check_capture(tag);
  endtask

  // pat 0: always ready, 1: 1,0,0,1 repeating, 2: random
  task automatic drain(input string tag, input int pat);
    int cyc;
    bit hs;
    logic [3:0] rpat;
    rpat = 4'b1001;
    cyc = 0;
    hs = 0;
    while (state == 2'd3 && cyc < 200) begin
      case (pat)
        0:       rd_ready = 1'b1;
        1:       rd_ready = rpat[cyc % 4];
        default: rd_ready = $urandom_range(0, 1);
      endcase
      @(negedge CLK);
      hs = rd_valid && rd_ready;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    chk({tag, "_idle"}, W'(state), W'(0));
    chk({tag, "_fill0"}, W'(fill), W'(0));
    chk({tag, "_rdv0"}, W'(rd_valid), W'(0));
    chk({tag, "_hs_then_idle"}, W'(hs), W'(1));
    chk({tag, "_all_read"}, W'(exp_q.size()), W'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (!Reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q[0]);
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] base;
    Reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = '0;
    probe_valid = 1'b0; probe_in = '0; rd_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", W'(state), W'(0));
    chk("rst_fill", W'(fill), W'(0));
    chk("rst_rdv", W'(rd_valid), W'(0));
    chk("rst_rd_data", rd_data, '0);
    chk("rst_trig", W'(triggered), W'(0));
    chk("rst_ovw", W'(overwrote), W'(0));
    Reset = 1'b0;
    tick();

    // Probe in IDLE is ignored.
    send_sample(32'h0);
    chk("idle_ignore_fill", W'(fill), W'(0));

    // Trigger without wrap; extra sample in READOUT is ignored.
    do_arm(1'b1, 32'h08);
    run_capture("t1", 32'h00, 1'b0);
    send_sample(32'h10);
    chk("t1_ignore_fill", W'(fill), W'(exp_fill));
    drain("t1", 0);

    // Trigger after wrap.
    do_arm(1'b1, 32'h20);
    run_capture("t2", 32'h00, 1'b0);
    drain("t2", 0);

    // Stop-when-full with gaps, extra sample ignored, stalled readback.
    do_arm(1'b0, 32'h00);
    run_capture("t3", 32'h40, 1'b1);
    send_sample(32'h99);
    chk("t3_ignore_fill", W'(fill), W'(DEPTH));
    drain("t3", 1);

    // Abort in POST with fill 3, then abort+arm together, then clean restart.
    do_arm(1'b1, 32'h108);
    send_sample(32'h100);
    send_sample(32'h104);
    send_sample(32'h108);
    chk("t5_post_state", W'(state), W'(2));
    chk("t5_post_fill", W'(fill), W'(3));
    abort = 1'b1; probe_valid = 1'b1; probe_in = {$urandom(), $urandom(), $urandom(), 32'h10c};
    model_clear();
    tick();
    abort = 1'b0; probe_valid = 1'b0;
    chk("t5_abort_state", W'(state), W'(0));
    chk("t5_abort_fill", W'(fill), W'(0));
    chk("t5_abort_rdv", W'(rd_valid), W'(0));
    chk("t5_abort_trig", W'(triggered), W'(0));
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("t5_abort_arm_state", W'(state), W'(0));
    do_arm(1'b1, 32'h208);
    run_capture("t5r", 32'h200, 1'b1);
    drain("t5r", 2);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      base = DATA_W'($urandom_range(0, 1023)) << 2;
      do_arm(1'($urandom_range(0, 1)), base + DATA_W'($urandom_range(0, 9)) * 4);
      run_capture("rnd", base, 1'b1);
      drain("rnd", 2);
    end

    // Asynchronous reset between clock edges during READOUT.
    do_arm(1'b1, 32'h300);
    run_capture("t6", 32'h2f0, 1'b0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_async_state", W'(state), W'(0));
    chk("t6_async_fill", W'(fill), W'(0));
    chk("t6_async_rdv", W'(rd_valid), W'(0));
    chk("t6_async_rd_data", rd_data, '0);
    chk("t6_async_trig", W'(triggered), W'(0));
    model_clear();
    @(negedge CLK);
    Reset = 1'b0;
    tick();
    do_arm(1'b0, 32'h0);
    run_capture("t6r", 32'h500, 1'b1);
    drain("t6r", 1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised, synthesizable trace capture block for the single-cycle CPU. It records NUM_CH probe words per retired instruction, such as PC, Inst, alu_result and Data2, into a circular buffer. Capture can freeze on a PC-match trigger with a configurable post-trigger window, or stop when the buffer is full. After capture, the buffer is drained oldest-first over a valid/ready port, replacing waveform dumping for on-target debug.

Parameters:
DATA_W, 32, width of one probe channel
NUM_CH, 4, probe channels per sample; channel 0 is the PC and is compared against trig_pc
DEPTH, 16, samples held; power of two, >= 2
POST_TRIG, 8, samples captured after the trigger sample; 0 <= POST_TRIG <= DEPTH-1
(local) AW = clog2(DEPTH)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
arm  in  1  start capture; honoured only in IDLE
abort  in  1  return to IDLE from any state; discards contents
trig_en  in  1  1 = PC-trigger mode, 0 = stop-when-full mode; sampled on the arm cycle
trig_pc  in  DATA_W  trigger address; sampled on the arm cycle
probe_valid  in  1  one instruction retired this cycle
probe_in  in  NUM_CH*DATA_W  probe words; channel k occupies bits [k*DATA_W +: DATA_W]
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data holds an unread sample
rd_data  out  NUM_CH*DATA_W  oldest unread sample
fill  out  AW+1  number of valid samples, saturating at DEPTH
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READOUT
triggered  out  1  trigger seen since the last arm
overwrote  out  1  history wrapped (older samples lost) during ARMED

Behaviour:
- Reset (async) values: state=IDLE, write pointer=0, fill=0, post counter=0, triggered=0, overwrote=0, rd_valid=0, rd_data=0. Buffer RAM contents are not reset.
- A sample write means: on a probe_valid cycle in ARMED or POST, store probe_in at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH and fill = min(fill+1, DEPTH).
- Priority each cycle, highest first: abort, then the state-machine action. abort forces IDLE, fill=0, rd_valid=0 and clears the flags. An abort on the same cycle as arm results in IDLE.
- IDLE: if arm, latch trig_en/trig_pc, set wr_ptr=0, fill=0, clear triggered and overwrote, and go to ARMED. Ignore probe_valid.
- ARMED, trig_en=1:
  - Write every valid sample.
  - Writing while fill==DEPTH sets overwrote.
  - A valid sample with channel 0 == trig_pc is written, sets triggered, loads post_cnt=POST_TRIG, and goes to POST. If POST_TRIG==0, go directly to READOUT instead.
- ARMED, trig_en=0:
  - Write valid samples.
  - On the write that makes fill==DEPTH, go to READOUT. No overwrite occurs.
  - triggered stays 0.
- POST:
  - Each valid sample is written and decrements post_cnt.
  - The write that brings post_cnt to 0 goes to READOUT.
  - A PC match in POST has no effect.
- Trigger sample position: the trigger sample is always retained. The buffer holds at most DEPTH-1-POST_TRIG pre-trigger samples.
- READOUT:
  - rd_ptr = (wr_ptr - fill) mod DEPTH on entry.
  - rd_valid=1 while unread > 0.
  - A transfer occurs when rd_valid && rd_ready; it advances rd_ptr mod DEPTH and decrements unread.
  - After the transfer of the last sample: rd_valid=0, state=IDLE, fill=0.
  - rd_data is stable while rd_valid && !rd_ready.
  - The RAM is read combinationally or through registered prefetch. Either way, rd_data is valid in the same cycle rd_valid is high, including the first cycle of READOUT.
  - probe_valid and arm are ignored in READOUT.
- rd_ptr and wr_ptr wrap naturally mod DEPTH. fill never exceeds DEPTH.
- The trigger comparison uses the live probe_in channel 0 on the valid cycle. It is purely combinational equality, with no registered latency.

Decomposition:
- A shared package trace_pkg holds:
  - the state encoding constants (IDLE/ARMED/POST/READOUT);
  - the channel-slice helper;
  - the constant for the PC channel index, 0.
- One sub-module, trace_ram: a DEPTH x (NUM_CH*DATA_W) simple dual-port RAM with one synchronous write port and one read port.
- The FSM, pointers and counters stay in cpu_trace_buffer.

Test Plan:
1. DEPTH=4, POST_TRIG=1, trig_en=1, trig_pc=0x08. PC stream 0x00,0x04,0x08,0x0C,0x10 -> READOUT after 0x0C. Reads return 0x00,0x04,0x08,0x0C. triggered=1, overwrote=0.
2. Same configuration, PC stream 0x00..0x1C step 4 then 0x20=trig_pc -> overwrote=1. Reads return 0x1C,0x20,0x24 plus the preceding 0x18 (4 samples, oldest first, correct wrap).
3. trig_en=0, DEPTH=16 -> exactly 16 valid samples are captured and the 17th is ignored. fill=16, and 16 reads are in order. probe_valid gaps do not create entries.
4. Readback with rd_ready toggling 1,0,0,1 -> rd_data holds during stalls and no sample is skipped or duplicated. state returns to IDLE on the cycle after the last handshake.
5. abort asserted in POST with fill=3 -> next cycle state=IDLE, fill=0, rd_valid=0. A subsequent arm restarts cleanly.
6. Reset asserted asynchronously mid-READOUT, between clock edges -> outputs reach their reset values immediately, without waiting for CLK.
